// File: rtl/sr164_pkg.sv
// Shared constants and width helpers for the 74164 chain load controller.
package sr164_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CLEAR = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic int chain_bits(input int chain_bytes);
        return 8 * chain_bytes;
    endfunction

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int bit_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Guarded so an illegal CLK_DIV still elaborates far enough to hit the range check.
    function automatic int phase_width(input int clk_div);
        return (clk_div >= 1) ? $clog2(2 * clk_div) : 1;
    endfunction

endpackage

// File: rtl/sr164_rr_arb.sv
// Round-robin arbiter: combinational grant from the valid vector, pointer advances past each accepted index.
module sr164_rr_arb
    import sr164_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDW     = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               accept,
    output logic               any,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id
);

    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] ptr_next;

    // First pass searches from the pointer upward, second pass wraps to the low indices.
    always_comb begin
        any      = 1'b0;
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && valid[i] && (i >= int'(ptr_reg))) begin
                any      = 1'b1;
                grant_id = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && valid[i]) begin
                any      = 1'b1;
                grant_id = IDW'(i);
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign grant[gi] = any && (grant_id == IDW'(gi));
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (accept) begin
            ptr_next = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/sr164_load_ctrl.sv
// Loads parallel words from several requesters into a cascaded 74164 chain, MSB first,
// with an optional chain clear ahead of the shift.
module sr164_load_ctrl
    import sr164_pkg::*;
#(
    parameter  int NUM_REQ     = 2,
    parameter  int CHAIN_BYTES = 1,
    parameter  int CLK_DIV     = 4,
    localparam int N           = chain_bits(CHAIN_BYTES),
    localparam int IDW         = id_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_clear,
    input  logic [NUM_REQ*N-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 sr_clk,
    output logic                 sr_a,
    output logic                 sr_b,
    output logic                 sr_clr_n,
    output logic                 busy,
    output logic                 done,
    output logic [IDW-1:0]       done_id
);

    localparam int BW = bit_cnt_width(N);
    localparam int PW = phase_width(CLK_DIV);

    localparam logic [PW-1:0] CLEAR_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] RISE_PHASE = PW'(CLK_DIV);
    localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("sr164_load_ctrl: CLK_DIV must be >= 1");
    end
    if (NUM_REQ < 1) begin : g_bad_num_req
        $error("sr164_load_ctrl: NUM_REQ must be >= 1");
    end

    state_t         state_reg, state_next;
    logic [PW-1:0]  phase_reg, phase_next;
    logic [BW-1:0]  bit_reg, bit_next;
    logic [N-1:0]   word_reg, word_next;
    logic [IDW-1:0] id_reg, id_next;
    logic           sr_clk_reg, sr_a_reg, sr_clr_n_reg, done_reg;

    logic               any_valid;
    logic               accept;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_id;
    logic [N-1:0]       grant_word;
    logic [N-1:0]       req_words [NUM_REQ];

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_words
        assign req_words[gi] = req_data[gi*N +: N];
    end

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_word = req_words[i];
            end
        end
    end

    sr164_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk      (clk),
        .clr_n    (clr_n),
        .valid    (req_valid),
        .accept   (accept),
        .any      (any_valid),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // sr_clr_n_reg is low only in reset and CLEAR, so it also holds off grants until the first clk after reset.
    assign accept    = (state_reg == ST_IDLE) && sr_clr_n_reg && any_valid;
    assign req_ready = accept ? grant : '0;

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        bit_next   = bit_reg;
        word_next  = word_reg;
        id_next    = id_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    word_next  = grant_word;
                    id_next    = grant_id;
                    phase_next = '0;
                    bit_next   = '0;
                    state_next = |(req_clear & grant) ? ST_CLEAR : ST_SHIFT;
                end
            end
            ST_CLEAR: begin
                if (phase_reg == CLEAR_LAST) begin
                    phase_next = '0;
                    state_next = ST_SHIFT;
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            ST_SHIFT: begin
                if (phase_reg == PHASE_LAST) begin
                    phase_next = '0;
                    word_next  = word_reg << 1;
                    bit_next   = bit_reg + BW'(1);
                    if (bit_reg == BIT_LAST) begin
                        state_next = ST_DONE;
                    end
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Chain-facing outputs are registered from the next-state values so they line up with the state they belong to.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg    <= ST_IDLE;
            phase_reg    <= '0;
            bit_reg      <= '0;
            word_reg     <= '0;
            id_reg       <= '0;
            sr_clk_reg   <= 1'b0;
            sr_a_reg     <= 1'b0;
            sr_clr_n_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            bit_reg      <= bit_next;
            word_reg     <= word_next;
            id_reg       <= id_next;
            sr_clk_reg   <= (state_next == ST_SHIFT) && (phase_next >= RISE_PHASE);
            sr_a_reg     <= (state_next == ST_SHIFT) && word_next[N-1];
            sr_clr_n_reg <= (state_next != ST_CLEAR);
            done_reg     <= (state_next == ST_DONE);
        end
    end

    assign sr_clk   = sr_clk_reg;
    assign sr_a     = sr_a_reg;
    assign sr_b     = 1'b1;
    assign sr_clr_n = sr_clr_n_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;
    assign done_id  = id_reg;

endmodule

// File: tb/tb_sr164_load_ctrl.sv
// Bench for sr164_load_ctrl: two configurations, each driving a behavioural 74164 chain model.
module tb_sr164_load_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Configuration A: 2 requesters, 1 byte, CLK_DIV=4
    logic        a_clr_n;
    logic [1:0]  a_req_valid, a_req_clear, a_req_ready;
    logic [15:0] a_req_data;
    logic        a_sr_clk, a_sr_a, a_sr_b, a_sr_clr_n, a_busy, a_done;
    logic [0:0]  a_done_id;

    // Configuration B: 2 requesters, 2 bytes, CLK_DIV=1
    logic        b_clr_n;
    logic [1:0]  b_req_valid, b_req_clear, b_req_ready;
    logic [31:0] b_req_data;
    logic        b_sr_clk, b_sr_a, b_sr_b, b_sr_clr_n, b_busy, b_done;
    logic [0:0]  b_done_id;

    sr164_load_ctrl #(.NUM_REQ(2), .CHAIN_BYTES(1), .CLK_DIV(4)) u_a (
        .clk(clk), .clr_n(a_clr_n), .req_valid(a_req_valid), .req_clear(a_req_clear),
        .req_data(a_req_data), .req_ready(a_req_ready), .sr_clk(a_sr_clk), .sr_a(a_sr_a),
        .sr_b(a_sr_b), .sr_clr_n(a_sr_clr_n), .busy(a_busy), .done(a_done), .done_id(a_done_id)
    );

    sr164_load_ctrl #(.NUM_REQ(2), .CHAIN_BYTES(2), .CLK_DIV(1)) u_b (
        .clk(clk), .clr_n(b_clr_n), .req_valid(b_req_valid), .req_clear(b_req_clear),
        .req_data(b_req_data), .req_ready(b_req_ready), .sr_clk(b_sr_clk), .sr_a(b_sr_a),
        .sr_b(b_sr_b), .sr_clr_n(b_sr_clr_n), .busy(b_busy), .done(b_done), .done_id(b_done_id)
    );

    // 74164 chain models: async clear, shift A&B in on sr_clk rise
    logic [7:0]  a_chain;
    logic [15:0] b_chain;
    int a_rises = 0;
    int b_rises = 0;

    always @(posedge a_sr_clk or negedge a_sr_clr_n) begin
        if (!a_sr_clr_n) a_chain <= '0;
        else             a_chain <= {a_chain[6:0], a_sr_a & a_sr_b};
    end
    always @(posedge b_sr_clk or negedge b_sr_clr_n) begin
        if (!b_sr_clr_n) b_chain <= '0;
        else             b_chain <= {b_chain[14:0], b_sr_a & b_sr_b};
    end
    always @(posedge a_sr_clk) a_rises++;
    always @(posedge b_sr_clk) b_rises++;

    // Round-robin reference: first valid index at or after the pointer, wrapping
    int a_ptr_m = 0;
    int b_ptr_m = 0;

    function automatic int rr_pick(input logic [1:0] v, input int ptr);
        for (int off = 0; off < 2; off++) begin
            if (v[(ptr + off) % 2]) return (ptr + off) % 2;
        end
        return -1;
    endfunction

    task automatic wait_accept_a(output logic [1:0] rdy, output int t0, output int r0, output bit ok);
        int n = 0;
        #1;
        while (a_req_ready == 2'b00 && n < 300) begin
            @(negedge clk); #1; n++;
        end
        rdy = a_req_ready; t0 = cyc; r0 = a_rises; ok = (a_req_ready != 2'b00);
    endtask

    task automatic wait_done_a(input int t0, input int r0, input int early_cyc, output int lat,
                               output int id, output int rises, output int clr_low,
                               output logic [7:0] early, output bit ok);
        int n = 0;
        ok = 0; lat = -1; id = -1; rises = 0; clr_low = 0; early = 8'hxx;
        while (!a_done && n < 3000) begin
            if (!a_sr_clr_n) clr_low++;
            if (cyc == early_cyc) early = a_chain;
            @(negedge clk); n++;
        end
        if (a_done) begin
            ok = 1; lat = cyc - t0; id = int'(a_done_id); rises = a_rises - r0;
        end
    endtask

    task automatic wait_accept_b(output logic [1:0] rdy, output int t0, output int r0, output bit ok);
        int n = 0;
        #1;
        while (b_req_ready == 2'b00 && n < 300) begin
            @(negedge clk); #1; n++;
        end
        rdy = b_req_ready; t0 = cyc; r0 = b_rises; ok = (b_req_ready != 2'b00);
    endtask

    task automatic wait_done_b(input int t0, input int r0, output int lat, output int id,
                               output int rises, output bit ok);
        int n = 0;
        ok = 0; lat = -1; id = -1; rises = 0;
        while (!b_done && n < 3000) begin
            @(negedge clk); n++;
        end
        if (b_done) begin
            ok = 1; lat = cyc - t0; id = int'(b_done_id); rises = b_rises - r0;
        end
    endtask

    task automatic test_reset();
        a_clr_n = 1'b0; b_clr_n = 1'b0;
        a_req_valid = '0; a_req_clear = '0; a_req_data = '0;
        b_req_valid = '0; b_req_clear = '0; b_req_data = '0;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({a_sr_clk, a_sr_a, a_sr_b, a_sr_clr_n} !== 4'b0010) begin
            n_fail++; $display("FAIL reset_chain_pins: got %b expected 0010", {a_sr_clk, a_sr_a, a_sr_b, a_sr_clr_n});
        end
        n_checks++;
        if ({a_req_ready, a_busy, a_done, a_done_id} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_status: got %b expected 00000", {a_req_ready, a_busy, a_done, a_done_id});
        end
        n_checks++;
        if ({b_sr_clk, b_sr_a, b_sr_b, b_sr_clr_n, b_busy, b_done} !== 6'b001000) begin
            n_fail++; $display("FAIL reset_b: got %b expected 001000", {b_sr_clk, b_sr_a, b_sr_b, b_sr_clr_n, b_busy, b_done});
        end
        a_clr_n = 1'b1; b_clr_n = 1'b1;
        a_ptr_m = 0; b_ptr_m = 0;
        #1;
        n_checks++;
        if (a_sr_clr_n !== 1'b0) begin
            n_fail++; $display("FAIL release_clr_hold: got %b expected 0", a_sr_clr_n);
        end
        @(negedge clk);
        n_checks++;
        if ({a_sr_clr_n, a_busy, a_req_ready, b_sr_clr_n} !== 5'b10001) begin
            n_fail++; $display("FAIL release_first_clk: got %b expected 10001", {a_sr_clr_n, a_busy, a_req_ready, b_sr_clr_n});
        end
        $display("reset: A and B released");
    endtask

    task automatic test_single_load();
        logic [7:0] d, early;
        logic [1:0] rdy, exp_rdy;
        logic c;
        int r, exp_g, t0, r0, lat, id, rises, clr_low;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            d = (k == 0) ? 8'hA5 : 8'($urandom);
            r = (k == 0) ? 0 : int'($urandom_range(0, 1));
            c = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            a_req_data[r*8 +: 8] = d;
            a_req_clear[r] = c;
            a_req_valid[r] = 1'b1;
            exp_g = rr_pick(a_req_valid, a_ptr_m);
            exp_rdy = '0; exp_rdy[exp_g] = 1'b1;
            wait_accept_a(rdy, t0, r0, ok);
            n_checks++;
            if (!ok || rdy !== exp_rdy) begin
                n_fail++; $display("FAIL single_ready: got %b expected %b", rdy, exp_rdy);
            end
            a_ptr_m = (exp_g + 1) % 2;
            @(negedge clk);
            a_req_valid = '0; a_req_clear = '0;
            wait_done_a(t0, r0, c ? t0 + 5 : -1, lat, id, rises, clr_low, early, ok);
            n_checks++;
            if (!ok || lat != 65 + (c ? 4 : 0)) begin
                n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, 65 + (c ? 4 : 0));
            end
            n_checks++;
            if (id != r || rises != 8) begin
                n_fail++; $display("FAIL single_id_rises: got id=%0d rises=%0d expected id=%0d rises=8", id, rises, r);
            end
            n_checks++;
            if (a_chain !== d) begin
                n_fail++; $display("FAIL single_chain: got %02h expected %02h", a_chain, d);
            end
            n_checks++;
            if (clr_low != (c ? 4 : 0)) begin
                n_fail++; $display("FAIL single_clear_len: got %0d expected %0d", clr_low, c ? 4 : 0);
            end
            if (c) begin
                n_checks++;
                if (early !== 8'h00) begin
                    n_fail++; $display("FAIL single_cleared: got %02h expected 00", early);
                end
            end
            @(negedge clk);
            n_checks++;
            if ({a_done, a_busy} !== 2'b00) begin
                n_fail++; $display("FAIL single_after_done: got %b expected 00", {a_done, a_busy});
            end
            $display("xfer A req%0d data=%02h clear=%0d latency=%0d chain=%02h", r, d, c, lat, a_chain);
        end
    endtask

    task automatic test_clear_load();
        logic [7:0] early;
        logic [1:0] rdy;
        int t0, r0, lat, id, rises, clr_low;
        bit ok;
        @(negedge clk);
        a_req_data[7:0] = 8'hFF; a_req_clear = 2'b00; a_req_valid = 2'b01;
        wait_accept_a(rdy, t0, r0, ok);
        a_ptr_m = 1;
        @(negedge clk);
        a_req_valid = '0;
        wait_done_a(t0, r0, -1, lat, id, rises, clr_low, early, ok);
        n_checks++;
        if (!ok || a_chain !== 8'hFF) begin
            n_fail++; $display("FAIL prefill_chain: got %02h expected ff", a_chain);
        end
        $display("xfer A req0 data=ff clear=0 latency=%0d chain=%02h", lat, a_chain);
        @(negedge clk);
        a_req_data[15:8] = 8'h3C; a_req_clear = 2'b10; a_req_valid = 2'b10;
        wait_accept_a(rdy, t0, r0, ok);
        n_checks++;
        if (!ok || rdy !== 2'b10) begin
            n_fail++; $display("FAIL clear_ready: got %b expected 10", rdy);
        end
        a_ptr_m = 0;
        @(negedge clk);
        a_req_valid = '0; a_req_clear = '0;
        wait_done_a(t0, r0, t0 + 5, lat, id, rises, clr_low, early, ok);
        n_checks++;
        if (clr_low != 4 || early !== 8'h00) begin
            n_fail++; $display("FAIL clear_phase: got low=%0d chain=%02h expected low=4 chain=00", clr_low, early);
        end
        n_checks++;
        if (!ok || lat != 69 || id != 1) begin
            n_fail++; $display("FAIL clear_done: got lat=%0d id=%0d expected lat=69 id=1", lat, id);
        end
        n_checks++;
        if (a_chain !== 8'h3C) begin
            n_fail++; $display("FAIL clear_chain: got %02h expected 3c", a_chain);
        end
        $display("xfer A req1 data=3c clear=1 latency=%0d chain=%02h", lat, a_chain);
    endtask

    task automatic test_round_robin();
        logic [1:0] pat, rdy, exp_rdy;
        logic [7:0] exp_d, early;
        int exp_g, t0, r0, lat, id, rises, clr_low;
        bit ok;
        for (int k = 0; k < 6; k++) begin
            pat = (k < 3) ? 2'b11 : 2'($urandom_range(1, 3));
            @(negedge clk);
            a_req_data = 16'($urandom); a_req_clear = '0; a_req_valid = pat;
            exp_g = rr_pick(pat, a_ptr_m);
            exp_rdy = '0; exp_rdy[exp_g] = 1'b1;
            exp_d = a_req_data[exp_g*8 +: 8];
            wait_accept_a(rdy, t0, r0, ok);
            n_checks++;
            if (!ok || rdy !== exp_rdy) begin
                n_fail++; $display("FAIL rr_grant: got %b expected %b (valid %b)", rdy, exp_rdy, pat);
            end
            a_ptr_m = (exp_g + 1) % 2;
            @(negedge clk);
            a_req_valid = '0;
            wait_done_a(t0, r0, -1, lat, id, rises, clr_low, early, ok);
            n_checks++;
            if (!ok || id != exp_g || a_chain !== exp_d) begin
                n_fail++; $display("FAIL rr_result: got id=%0d chain=%02h expected id=%0d chain=%02h", id, a_chain, exp_g, exp_d);
            end
            $display("xfer A valid=%b granted req%0d data=%02h chain=%02h", pat, exp_g, exp_d, a_chain);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] d, early;
        logic [1:0] rdy;
        int t0, r0, lat, id, rises, clr_low;
        bit ok, saw_done;
        d = 8'($urandom) | 8'h01;
        @(negedge clk);
        a_req_data[7:0] = d; a_req_clear = '0; a_req_valid = 2'b01;
        wait_accept_a(rdy, t0, r0, ok);
        @(negedge clk);
        saw_done = 0;
        while (cyc < t0 + 25) begin
            if (a_done) saw_done = 1;
            @(negedge clk);
        end
        n_checks++;
        if (a_rises - r0 != 3 || saw_done) begin
            n_fail++; $display("FAIL midshift_progress: got rises=%0d done=%0d expected rises=3 done=0", a_rises - r0, saw_done);
        end
        a_clr_n = 1'b0;
        a_ptr_m = 0;
        #1;
        n_checks++;
        if ({a_sr_clk, a_sr_a, a_sr_b, a_sr_clr_n, a_req_ready, a_busy, a_done, a_done_id} !== 9'b001000000) begin
            n_fail++; $display("FAIL midshift_reset_outputs: got %b expected 001000000",
                {a_sr_clk, a_sr_a, a_sr_b, a_sr_clr_n, a_req_ready, a_busy, a_done, a_done_id});
        end
        n_checks++;
        if (a_chain !== 8'h00) begin
            n_fail++; $display("FAIL midshift_chain_cleared: got %02h expected 00", a_chain);
        end
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({a_done, a_req_ready} !== 3'b000) begin
            n_fail++; $display("FAIL midshift_in_reset: got %b expected 000", {a_done, a_req_ready});
        end
        a_clr_n = 1'b1;
        #1;
        n_checks++;
        if (a_req_ready !== 2'b00) begin
            n_fail++; $display("FAIL midshift_early_ready: got %b expected 00", a_req_ready);
        end
        @(negedge clk); #1;
        n_checks++;
        if (a_req_ready !== 2'b01) begin
            n_fail++; $display("FAIL midshift_reaccept: got %b expected 01", a_req_ready);
        end
        t0 = cyc; r0 = a_rises;
        a_ptr_m = 1;
        @(negedge clk);
        a_req_valid = '0;
        wait_done_a(t0, r0, -1, lat, id, rises, clr_low, early, ok);
        n_checks++;
        if (!ok || lat != 65 || a_chain !== d) begin
            n_fail++; $display("FAIL midshift_retry: got lat=%0d chain=%02h expected lat=65 chain=%02h", lat, a_chain, d);
        end
        $display("xfer A reset mid-shift, retried data=%02h latency=%0d chain=%02h", d, lat, a_chain);
    endtask

    task automatic test_wide_chain();
        logic [15:0] d;
        logic [1:0] rdy, exp_rdy;
        logic c;
        int r, exp_g, t0, r0, lat, id, rises;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 16'h1234 : 16'($urandom);
            r = (k == 0) ? 0 : int'($urandom_range(0, 1));
            c = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            b_req_data[r*16 +: 16] = d; b_req_clear[r] = c; b_req_valid[r] = 1'b1;
            exp_g = rr_pick(b_req_valid, b_ptr_m);
            exp_rdy = '0; exp_rdy[exp_g] = 1'b1;
            wait_accept_b(rdy, t0, r0, ok);
            n_checks++;
            if (!ok || rdy !== exp_rdy) begin
                n_fail++; $display("FAIL wide_ready: got %b expected %b", rdy, exp_rdy);
            end
            b_ptr_m = (exp_g + 1) % 2;
            @(negedge clk);
            b_req_valid = '0; b_req_clear = '0;
            wait_done_b(t0, r0, lat, id, rises, ok);
            n_checks++;
            if (!ok || lat != 33 + (c ? 1 : 0) || rises != 16 || id != r) begin
                n_fail++; $display("FAIL wide_timing: got lat=%0d rises=%0d id=%0d expected lat=%0d rises=16 id=%0d",
                    lat, rises, id, 33 + (c ? 1 : 0), r);
            end
            n_checks++;
            if (b_chain !== d) begin
                n_fail++; $display("FAIL wide_chain: got %04h expected %04h", b_chain, d);
            end
            $display("xfer B req%0d data=%04h clear=%0d latency=%0d chain=%04h", r, d, c, lat, b_chain);
        end
    endtask

    task automatic test_withdrawal();
        logic [7:0] d;
        logic [1:0] rdy;
        int t0, r0, n, ready_seen, done_seen, quiet_bad;
        bit ok;
        d = 8'($urandom);
        @(negedge clk);
        a_req_data[7:0] = d; a_req_clear = '0; a_req_valid = 2'b01;
        wait_accept_a(rdy, t0, r0, ok);
        a_ptr_m = 1;
        @(negedge clk);
        a_req_valid = '0;
        ready_seen = 0; done_seen = 0; quiet_bad = 0; n = 0;
        while (!a_done && n < 3000) begin
            if (cyc == t0 + 10) a_req_valid = 2'b10;
            if (cyc == t0 + 11) a_req_valid = 2'b00;
            #1;
            if (a_req_ready != 2'b00) ready_seen++;
            @(negedge clk); n++;
        end
        if (a_done) done_seen++;
        n_checks++;
        if (ready_seen != 0 || done_seen != 1 || a_done_id !== 1'b0) begin
            n_fail++; $display("FAIL withdraw_during_busy: got ready=%0d done=%0d id=%0d expected 0 1 0",
                ready_seen, done_seen, a_done_id);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            if (a_req_ready != 2'b00 || a_done || a_busy) quiet_bad++;
        end
        n_checks++;
        if (quiet_bad != 0) begin
            n_fail++; $display("FAIL withdraw_quiet: got %0d active cycles expected 0", quiet_bad);
        end
        n_checks++;
        if (a_chain !== d) begin
            n_fail++; $display("FAIL withdraw_chain: got %02h expected %02h", a_chain, d);
        end
        $display("xfer A req0 data=%02h with withdrawn req1, chain=%02h", d, a_chain);
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_clear_load();
        test_round_robin();
        test_reset_mid_shift();
        test_wide_chain();
        test_withdrawal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
